ysyx_22040386_lsu: RTL and testbench
====================================

# ysyx_22040386_lsu

Load/store unit for the MEM stage of the ysyx_22040386 pipeline: it consumes the execute stage's result bundle, which carries the ALU address, store data, mem mask, MemRead/MemWrite and the writeback fields. It drives a single-outstanding valid/ready data-memory port, performs byte-lane alignment for stores and sign/zero extension for loads, and hands a writeback bundle to WB. Non-memory instructions pass through with one-cycle latency.

## Interface
- XLEN, 64, datapath width; only 64 supported.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream bundle valid.
- o_ready  out  1  LSU can accept a bundle (high only in IDLE).
- i_ALUresult  in  64  effective address, or ALU result for non-memory ops.
- i_reg_wr_data  in  64  writeback value for non-load ops.
- i_mem_wr_data  in  64  store data, low bytes significant.
- i_mem_mask  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- i_MemRead, i_MemWrite, i_RegWrite  in  1 each  control; MemRead and MemWrite are never both high.
- i_reg_wr_addr  in  5  destination register.
- o_mem_req_valid  out  1  request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_addr  out  64  address with bits [2:0] forced to 0.
- o_mem_wen  out  1  1 = store.
- o_mem_wdata  out  64  store data shifted into its byte lanes.
- o_mem_wstrb  out  8  byte strobes.
- i_mem_rsp_valid  in  1  response valid, for loads and stores.
- i_mem_rdata  in  64  8-byte-aligned read data.
- o_valid  out  1  writeback bundle valid.
- i_ready  in  1  WB accepts bundle.
- o_reg_wr_addr  out  5  registered destination register.
- o_RegWrite  out  1  registered; forced 0 on misalign.
- o_reg_wr_data  out  64  writeback value.
- o_misalign  out  1  access was misaligned; qualified by o_valid.

## Operation
- States: IDLE, REQ, RSP, DONE.
- IDLE: o_ready=1. On i_valid, latch the whole bundle and compute off = addr[2:0] and size = 1<<mask[1:0].
  - If neither MemRead nor MemWrite is set, go to DONE with o_reg_wr_data = i_reg_wr_data.
  - If MemRead or MemWrite is set and off is misaligned (off % size ≠ 0), go to DONE with o_misalign=1, o_RegWrite=0 and no bus activity.
  - Otherwise go to REQ.
- REQ: o_mem_req_valid=1. Store strobe = ((1<<size)-1) << off; wdata = i_mem_wr_data << (8*off). Address, wen, wdata and wstrb stay stable until i_mem_req_ready; the handshake moves to RSP.
- RSP: wait for i_mem_rsp_valid. For a load, take raw = rdata >> (8*off) and extend it to 64 bits: sign-extend for mask 000/001/010, zero-extend for 100/101/110, pass through for 011. For a store, data is ignored and o_reg_wr_data = 0. Then go to DONE.
- DONE: o_valid=1 with outputs held stable. On i_ready go to IDLE. The next bundle is accepted no earlier than the following cycle (no same-cycle turnaround).
- A response arriving in REQ is a protocol error and is ignored.
- Reset mid-transaction returns the FSM to IDLE. Any in-flight memory response after reset is dropped, because the FSM is not in RSP.

## Timing
- Reset values:
  - state = IDLE, o_ready = 1.
  - o_valid, o_mem_req_valid, o_mem_wen, o_RegWrite and o_misalign = 0.
  - All data and address outputs = 0 and o_mem_wstrb = 0.
- Non-memory or misaligned op: accepted at cycle T, o_valid at T+1.
- Memory op: accepted at T; o_mem_req_valid from T+1; request handshake at T+a (a≥1); response at T+a+r (r≥1); o_valid the cycle after the response.
- With zero-wait memory (ready and rsp_valid each one cycle after assertion) the minimum load latency is 3 cycles.
- All outputs are registered. There is no combinational path from any input to any output except that none exists by design, since o_ready is derived from state.

## Structure
- Shared package ysyx_22040386_pkg holds:
  - the state enum;
  - mask encodings as localparams MASK_B, MASK_H, MASK_W, MASK_D, MASK_BU, MASK_HU, MASK_WU.
- Sub-module ysyx_22040386_load_ext: combinational shift plus sign/zero extension of rdata by off and mask. It is unit-tested separately.

## Test plan
- Non-memory pass-through: i_valid with ALU result 0x1234 and RegWrite=1 → o_valid the next cycle, o_reg_wr_data=0x1234, no o_mem_req_valid.
- lb at address 0x8000_0003, rdata=0x0000_0000_8000_0000 → wb=0xFFFF_FFFF_FFFF_FF80; the lbu variant → 0x80.
- sh at address 0x8000_0006, data 0xBEEF → wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, addr=0x8000_0000.
- lw at address 0x8000_0002 → misalign: o_valid at T+1, o_misalign=1, o_RegWrite=0, no request.
- Backpressure:
  - hold i_mem_req_ready=0 for 5 cycles: the request stays stable;
  - hold i_ready=0 for 3 cycles: o_valid and the data stay stable, and o_ready stays 0.
- Assert rst_n low while in RSP: outputs reach reset values asynchronously, and a later rsp_valid produces no o_valid.

Source files
------------

// File: rtl/ysyx_22040386_pkg.sv
// Shared definitions for the ysyx_22040386 load/store unit: FSM states,
// funct3 mask encodings and the alignment/strobe helpers.
package ysyx_22040386_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_D  = 3'b011;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;
    localparam logic [2:0] MASK_WU = 3'b110;

    // An access is aligned when the offset has no bits below the access size.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size_log2);
        logic [2:0] low_bits;
        case (size_log2)
            2'd0:    low_bits = 3'b000;
            2'd1:    low_bits = 3'b001;
            2'd2:    low_bits = 3'b011;
            2'd3:    low_bits = 3'b111;
            default: low_bits = 3'b111;
        endcase
        return (off & low_bits) != 3'b000;
    endfunction

    function automatic logic [7:0] strobe(input logic [2:0] off, input logic [1:0] size_log2);
        logic [7:0] base;
        case (size_log2)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            2'd3:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_if.sv
// Single-outstanding valid/ready data-memory port between the LSU (master)
// and the data memory (slave).
interface ysyx_22040386_lsu_if;
    import ysyx_22040386_pkg::*;

    logic            o_mem_req_valid;
    logic            i_mem_req_ready;
    logic [XLEN-1:0] o_mem_addr;
    logic            o_mem_wen;
    logic [XLEN-1:0] o_mem_wdata;
    logic [7:0]      o_mem_wstrb;
    logic            i_mem_rsp_valid;
    logic [XLEN-1:0] i_mem_rdata;

    modport master (
        output o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
        input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata
    );

    modport slave (
        input  o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
        output i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata
    );

endinterface

// File: rtl/ysyx_22040386_load_ext.sv
// Load data formatter: shifts the addressed bytes of an aligned 8-byte word
// down to bit 0 and sign/zero extends them according to funct3.
module ysyx_22040386_load_ext
    import ysyx_22040386_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  logic [2:0]      i_mask,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_raw;

    // Byte-lane shift followed by width-dependent extension.
    always_comb begin
        w_raw  = i_rdata >> {i_off, 3'b000};
        o_data = w_raw;
        case (i_mask)
            MASK_B:  o_data = {{56{w_raw[7]}},  w_raw[7:0]};
            MASK_H:  o_data = {{48{w_raw[15]}}, w_raw[15:0]};
            MASK_W:  o_data = {{32{w_raw[31]}}, w_raw[31:0]};
            MASK_D:  o_data = w_raw;
            MASK_BU: o_data = {56'h0, w_raw[7:0]};
            MASK_HU: o_data = {48'h0, w_raw[15:0]};
            MASK_WU: o_data = {32'h0, w_raw[31:0]};
            default: o_data = w_raw;
        endcase
    end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// MEM-stage load/store unit: accepts one execute bundle at a time, runs at most
// one memory transaction, and presents a registered writeback bundle to WB.
module ysyx_22040386_lsu
    import ysyx_22040386_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [XLEN-1:0]      i_ALUresult,
    input  logic [XLEN-1:0]      i_reg_wr_data,
    input  logic [XLEN-1:0]      i_mem_wr_data,
    input  logic [2:0]           i_mem_mask,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic                 i_RegWrite,
    input  logic [4:0]           i_reg_wr_addr,
    ysyx_22040386_lsu_if.master  mem,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [4:0]           o_reg_wr_addr,
    output logic                 o_RegWrite,
    output logic [XLEN-1:0]      o_reg_wr_data,
    output logic                 o_misalign
);

    lsu_state_e      r_state,  w_state_n;
    logic [XLEN-1:0] r_addr,   w_addr_n;
    logic [XLEN-1:0] r_wdata,  w_wdata_n;
    logic [7:0]      r_wstrb,  w_wstrb_n;
    logic            r_wen,    w_wen_n;
    logic [2:0]      r_off,    w_off_n;
    logic [2:0]      r_mask,   w_mask_n;
    logic [4:0]      r_rd,     w_rd_n;
    logic            r_rw,     w_rw_n;
    logic [XLEN-1:0] r_data,   w_data_n;
    logic            r_mis,    w_mis_n;
    logic [2:0]      w_off;
    logic            w_mis;
    logic [XLEN-1:0] w_ext;

    ysyx_22040386_load_ext u_load_ext (
        .i_rdata (mem.i_mem_rdata),
        .i_off   (r_off),
        .i_mask  (r_mask),
        .o_data  (w_ext)
    );

    // Next-state and next-register logic; the bundle is latched only in IDLE.
    always_comb begin
        w_off     = i_ALUresult[2:0];
        w_mis     = misaligned(w_off, i_mem_mask[1:0]);
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_wstrb_n = r_wstrb;
        w_wen_n   = r_wen;
        w_off_n   = r_off;
        w_mask_n  = r_mask;
        w_rd_n    = r_rd;
        w_rw_n    = r_rw;
        w_data_n  = r_data;
        w_mis_n   = r_mis;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_addr_n  = {i_ALUresult[XLEN-1:3], 3'b000};
                    w_off_n   = w_off;
                    w_mask_n  = i_mem_mask;
                    w_wen_n   = i_MemWrite;
                    w_rd_n    = i_reg_wr_addr;
                    w_rw_n    = i_RegWrite;
                    w_mis_n   = 1'b0;
                    w_wstrb_n = i_MemWrite ? strobe(w_off, i_mem_mask[1:0]) : 8'h00;
                    w_wdata_n = i_MemWrite ? (i_mem_wr_data << {w_off, 3'b000}) : 64'h0;
                    if (!(i_MemRead || i_MemWrite)) begin
                        w_data_n  = i_reg_wr_data;
                        w_state_n = DONE;
                    end else if (w_mis) begin
                        w_mis_n   = 1'b1;
                        w_rw_n    = 1'b0;
                        w_data_n  = 64'h0;
                        w_state_n = DONE;
                    end else begin
                        w_data_n  = 64'h0;
                        w_state_n = REQ;
                    end
                end else begin
                    w_state_n = IDLE;
                end
            end
            REQ: begin
                // A response seen here is a protocol error and is dropped.
                if (mem.i_mem_req_ready) begin
                    w_state_n = RSP;
                end else begin
                    w_state_n = REQ;
                end
            end
            RSP: begin
                if (mem.i_mem_rsp_valid) begin
                    w_data_n  = r_wen ? 64'h0 : w_ext;
                    w_state_n = DONE;
                end else begin
                    w_state_n = RSP;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_n = IDLE;
                end else begin
                    w_state_n = DONE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // State and bundle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= 64'h0;
            r_wdata <= 64'h0;
            r_wstrb <= 8'h00;
            r_wen   <= 1'b0;
            r_off   <= 3'b000;
            r_mask  <= 3'b000;
            r_rd    <= 5'd0;
            r_rw    <= 1'b0;
            r_data  <= 64'h0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_wstrb <= w_wstrb_n;
            r_wen   <= w_wen_n;
            r_off   <= w_off_n;
            r_mask  <= w_mask_n;
            r_rd    <= w_rd_n;
            r_rw    <= w_rw_n;
            r_data  <= w_data_n;
            r_mis   <= w_mis_n;
        end
    end

    assign o_ready             = (r_state == IDLE);
    assign o_valid             = (r_state == DONE);
    assign mem.o_mem_req_valid = (r_state == REQ);
    assign mem.o_mem_addr      = r_addr;
    assign mem.o_mem_wen       = r_wen;
    assign mem.o_mem_wdata     = r_wdata;
    assign mem.o_mem_wstrb     = r_wstrb;
    assign o_reg_wr_addr       = r_rd;
    assign o_RegWrite          = r_rw;
    assign o_reg_wr_data       = r_data;
    assign o_misalign          = r_mis;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Directed bench for ysyx_22040386_lsu with a byte-level reference model and a
// per-cycle compare process.
module tb_ysyx_22040386_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_ALUresult = 64'h0;
    logic [63:0] i_reg_wr_data = 64'h0;
    logic [63:0] i_mem_wr_data = 64'h0;
    logic [2:0]  i_mem_mask = 3'b000;
    logic        i_MemRead = 1'b0;
    logic        i_MemWrite = 1'b0;
    logic        i_RegWrite = 1'b0;
    logic [4:0]  i_reg_wr_addr = 5'd0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [4:0]  o_reg_wr_addr;
    logic        o_RegWrite;
    logic [63:0] o_reg_wr_data;
    logic        o_misalign;

    ysyx_22040386_lsu_if mif ();

    ysyx_22040386_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_ALUresult   (i_ALUresult),
        .i_reg_wr_data (i_reg_wr_data),
        .i_mem_wr_data (i_mem_wr_data),
        .i_mem_mask    (i_mem_mask),
        .i_MemRead     (i_MemRead),
        .i_MemWrite    (i_MemWrite),
        .i_RegWrite    (i_RegWrite),
        .i_reg_wr_addr (i_reg_wr_addr),
        .mem           (mif.master),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_reg_wr_addr (o_reg_wr_addr),
        .o_RegWrite    (o_RegWrite),
        .o_reg_wr_data (o_reg_wr_data),
        .o_misalign    (o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bus;
        logic        mis;
        logic        rw;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wb;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic m_active = 1'b0;
    exp_t m_exp;
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: what WB and the bus must see, computed byte by byte.
    function automatic exp_t model(input logic [63:0] alu, input logic [63:0] rwd,
                                   input logic [63:0] wd, input logic [63:0] rdata,
                                   input logic [2:0] mask, input logic mr, input logic mw,
                                   input logic rw, input logic [4:0] rd);
        exp_t r;
        int size;
        int off;
        logic [63:0] v;
        size    = 1 << mask[1:0];
        off     = int'(alu[2:0]);
        r.addr  = {alu[63:3], 3'b000};
        r.wen   = mw;
        r.rd    = rd;
        r.strb  = 8'h00;
        r.wdata = 64'h0;
        r.wb    = 64'h0;
        r.mis   = (mr || mw) && ((off % size) != 0);
        r.bus   = (mr || mw) && !r.mis;
        r.rw    = rw && !r.mis;
        if (!(mr || mw)) begin
            r.wb = rwd;
        end else if (mr && !r.mis) begin
            v = 64'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
            if (!mask[2] && size < 8 && v[8*size-1])
                for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
            r.wb = v;
        end
        if (mw && !r.mis) begin
            for (int i = 0; i < size; i++) begin
                r.strb[off+i]             = 1'b1;
                r.wdata[8*(off+i) +: 8]   = wd[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Every cycle a bundle is in flight, bus and WB outputs must match the model.
    always @(negedge clk) begin
        if (rst_n && m_active) begin
            if (mif.o_mem_req_valid) begin
                chk("req_allowed", 64'(mif.o_mem_req_valid), 64'(m_exp.bus));
                chk("mem_addr", mif.o_mem_addr, m_exp.addr);
                chk("mem_wen", 64'(mif.o_mem_wen), 64'(m_exp.wen));
                if (m_exp.wen) begin
                    chk("mem_wdata", mif.o_mem_wdata, m_exp.wdata);
                    chk("mem_wstrb", 64'(mif.o_mem_wstrb), 64'(m_exp.strb));
                end
            end
            if (o_valid) begin
                chk("wb_rd", 64'(o_reg_wr_addr), 64'(m_exp.rd));
                chk("wb_regwrite", 64'(o_RegWrite), 64'(m_exp.rw));
                chk("wb_misalign", 64'(o_misalign), 64'(m_exp.mis));
                if (!m_exp.mis) chk("wb_data", o_reg_wr_data, m_exp.wb);
            end
        end
    end

    task automatic run_op(input logic [63:0] alu, input logic [63:0] rwd, input logic [63:0] wd,
                          input logic [63:0] rdata, input logic [2:0] mask, input logic mr,
                          input logic mw, input logic rw, input logic [4:0] rd,
                          input int req_wait, input int rsp_wait, input int wb_wait,
                          output exp_t r);
        r        = model(alu, rwd, wd, rdata, mask, mr, mw, rw, rd);
        m_exp    = r;
        m_active = 1'b1;
        @(negedge clk);
        chk("ready_idle", 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_ALUresult = alu; i_reg_wr_data = rwd; i_mem_wr_data = wd;
        i_mem_mask = mask; i_MemRead = mr; i_MemWrite = mw; i_RegWrite = rw; i_reg_wr_addr = rd;
        @(negedge clk);
        i_valid = 1'b0;
        if (!r.bus) begin
            chk("valid_next", 64'(o_valid), 64'd1);
            chk("no_req", 64'(mif.o_mem_req_valid), 64'd0);
        end else begin
            chk("req_next", 64'(mif.o_mem_req_valid), 64'd1);
            chk("ready_busy", 64'(o_ready), 64'd0);
            for (int k = 0; k < req_wait; k++) begin
                // A stray response while waiting for the handshake must be ignored.
                mif.i_mem_rsp_valid = (k == 0);
                mif.i_mem_rdata     = ~rdata;
                @(negedge clk);
                mif.i_mem_rsp_valid = 1'b0;
            end
            chk("req_held", 64'(mif.o_mem_req_valid), 64'd1);
            mif.i_mem_req_ready = 1'b1;
            @(negedge clk);
            mif.i_mem_req_ready = 1'b0;
            chk("req_dropped", 64'(mif.o_mem_req_valid), 64'd0);
            for (int k = 0; k < rsp_wait; k++) @(negedge clk);
            chk("no_valid_before_rsp", 64'(o_valid), 64'd0);
            mif.i_mem_rdata     = rdata;
            mif.i_mem_rsp_valid = 1'b1;
            @(negedge clk);
            mif.i_mem_rsp_valid = 1'b0;
            chk("valid_after_rsp", 64'(o_valid), 64'd1);
        end
        for (int k = 0; k < wb_wait; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("released", 64'(o_valid), 64'd0);
        chk("idle_again", 64'(o_ready), 64'd1);
        m_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mif.i_mem_req_ready = 1'b0;
        mif.i_mem_rsp_valid = 1'b0;
        mif.i_mem_rdata     = 64'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_req", 64'(mif.o_mem_req_valid), 64'd0);
        chk("rst_wen", 64'(mif.o_mem_wen), 64'd0);
        chk("rst_wstrb", 64'(mif.o_mem_wstrb), 64'd0);
        chk("rst_addr", mif.o_mem_addr, 64'd0);
        chk("rst_data", o_reg_wr_data, 64'd0);
        chk("rst_misalign", 64'(o_misalign), 64'd0);
        rst_n = 1'b1;

        // Non-memory pass-through.
        run_op(64'h1234, 64'h1234, 64'h0, 64'h0, 3'b011, 1'b0, 1'b0, 1'b1, 5'd5, 0, 0, 0, e);
        chk("pin_passthru", e.wb, 64'h1234);
        // lb / lbu with zero-wait memory.
        run_op(64'h8000_0003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 3'b000, 1'b1, 1'b0, 1'b1,
               5'd10, 0, 0, 0, e);
        chk("pin_lb", e.wb, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(64'h8000_0003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 3'b100, 1'b1, 1'b0, 1'b1,
               5'd11, 0, 0, 0, e);
        chk("pin_lbu", e.wb, 64'h80);
        // sh with request and writeback backpressure.
        run_op(64'h8000_0006, 64'h0, 64'h0000_0000_0000_BEEF, 64'h0, 3'b001, 1'b0, 1'b1, 1'b0,
               5'd0, 5, 2, 3, e);
        chk("pin_sh_strb", 64'(e.strb), 64'hC0);
        chk("pin_sh_wdata", e.wdata, 64'hBEEF_0000_0000_0000);
        chk("pin_sh_addr", e.addr, 64'h8000_0000);
        // Misaligned lw.
        run_op(64'h8000_0002, 64'h0, 64'h0, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd7, 0, 0, 1, e);
        chk("pin_lw_mis", 64'(e.mis), 64'd1);
        // Further loads and stores across lanes and extensions.
        run_op(64'h8000_0008, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 3'b011, 1'b1, 1'b0, 1'b1,
               5'd12, 2, 1, 0, e);
        run_op(64'h8000_0002, 64'h0, 64'h0, 64'h0000_0000_F00D_0000, 3'b001, 1'b1, 1'b0, 1'b1,
               5'd13, 0, 0, 0, e);
        run_op(64'h8000_0002, 64'h0, 64'h0, 64'h0000_0000_F00D_0000, 3'b101, 1'b1, 1'b0, 1'b1,
               5'd14, 1, 0, 0, e);
        run_op(64'h8000_0004, 64'h0, 64'h0, 64'h9ABC_DEF0_0000_0000, 3'b110, 1'b1, 1'b0, 1'b1,
               5'd15, 0, 2, 0, e);
        run_op(64'h8000_0004, 64'h0, 64'h0, 64'h9ABC_DEF0_0000_0000, 3'b010, 1'b1, 1'b0, 1'b1,
               5'd16, 0, 0, 0, e);
        run_op(64'h8000_0010, 64'h0, 64'h1122_3344_5566_7788, 64'h0, 3'b011, 1'b0, 1'b1, 1'b0,
               5'd0, 0, 0, 0, e);
        run_op(64'h8000_0015, 64'h0, 64'h0000_0000_0000_00A5, 64'h0, 3'b000, 1'b0, 1'b1, 1'b0,
               5'd0, 1, 1, 0, e);
        run_op(64'h8000_0019, 64'h0, 64'h0, 64'h0, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0, 0, e);

        // Reset while waiting for a load response.
        e = model(64'h8000_0020, 64'h0, 64'h0, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd3);
        m_exp = e;
        m_active = 1'b1;
        @(negedge clk);
        i_valid = 1'b1; i_ALUresult = 64'h8000_0020; i_mem_mask = 3'b011;
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_RegWrite = 1'b1; i_reg_wr_addr = 5'd3;
        @(negedge clk);
        i_valid = 1'b0;
        mif.i_mem_req_ready = 1'b1;
        @(negedge clk);
        mif.i_mem_req_ready = 1'b0;
        chk("rsp_state_no_req", 64'(mif.o_mem_req_valid), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_addr", mif.o_mem_addr, 64'd0);
        chk("arst_data", o_reg_wr_data, 64'd0);
        chk("arst_regwrite", 64'(o_RegWrite), 64'd0);
        m_active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mif.i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        mif.i_mem_rsp_valid = 1'b1;
        @(negedge clk);
        mif.i_mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_rsp_dropped", 64'(o_valid), 64'd0);
            @(negedge clk);
        end
        // Recovery after reset.
        run_op(64'h42, 64'h0000_0000_CAFE_F00D, 64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1,
               5'd31, 0, 0, 0, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
